// File: rtl/vga_timing_generator.sv
// ---------------------------------------------------------------------------
// vga_timing_generator
//
// Free-running raster timing for the VGA output path. A horizontal counter
// runs at pixel rate; the vertical counter advances once per line. Every
// output is registered from the same (h_cnt, v_cnt) pair, so on any given
// cycle row, column, the syncs, the enables and the strobes all describe
// the same pixel.
//
// Ports:
//   vga_clock       pixel clock, all logic on its rising edge
//   reset           asynchronous, active-high reset
//   row             vertical position of the current pixel (0..V_TOTAL-1)
//   column          horizontal position of the current pixel (0..H_TOTAL-1)
//   display_enable  high inside the visible area
//   hsync, vsync    sync pins, asserted at level SYNC_ACTIVE
//   line_start      one-cycle strobe at column 0
//   frame_start     one-cycle strobe at column 0, row 0
//   vblank          high while row >= V_VISIBLE
//   frame_count     frames started since reset, wraps modulo 2^32
// ---------------------------------------------------------------------------
module vga_timing_generator #(
    parameter int   H_VISIBLE   = 640,
    parameter int   H_FRONT     = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BACK      = 48,
    parameter int   V_VISIBLE   = 480,
    parameter int   V_FRONT     = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BACK      = 33,
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  logic               vga_clock,
    input  logic               reset,
    output logic signed [31:0] row,
    output logic signed [31:0] column,
    output logic               display_enable,
    output logic               hsync,
    output logic               vsync,
    output logic               line_start,
    output logic               frame_start,
    output logic               vblank,
    output logic [31:0]        frame_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    // Boundaries pre-sized to the counter widths so every compare is
    // width-matched.
    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS_END  = HW'(H_VISIBLE);
    localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_VISIBLE + H_FRONT);
    localparam logic [HW-1:0] H_SYNC_END = HW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS_END  = VW'(V_VISIBLE);
    localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_VISIBLE + V_FRONT);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;

    // Decoded view of the pixel the counters currently point at.
    logic h_active;
    logic v_active;
    logic h_sync_on;
    logic v_sync_on;
    logic at_line_start;
    logic at_frame_start;

    // ------------------------------------------------------------------
    // Raster counters: never stall, wrap at the end of line / frame.
    // ------------------------------------------------------------------
    always_ff @(posedge vga_clock or posedge reset) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            if (v_cnt == V_LAST) begin
                v_cnt <= '0;
            end else begin
                v_cnt <= v_cnt + 1'b1;
            end
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Decode of the current counter pair.
    // ------------------------------------------------------------------
    always_comb begin
        h_active       = (h_cnt < H_VIS_END);
        v_active       = (v_cnt < V_VIS_END);
        h_sync_on      = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
        // Decoded from v_cnt alone; because the registered outputs move
        // with the counters, vsync only changes when column returns to 0.
        v_sync_on      = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);
        at_line_start  = (h_cnt == '0);
        at_frame_start = (h_cnt == '0) && (v_cnt == '0);
    end

    // ------------------------------------------------------------------
    // Output register: one stage, all outputs captured from the same
    // counter pair so there is no skew between them.
    // ------------------------------------------------------------------
    always_ff @(posedge vga_clock or posedge reset) begin
        if (reset) begin
            row            <= '0;
            column         <= '0;
            display_enable <= 1'b0;
            hsync          <= ~SYNC_ACTIVE;
            vsync          <= ~SYNC_ACTIVE;
            line_start     <= 1'b0;
            frame_start    <= 1'b0;
            vblank         <= 1'b0;
            frame_count    <= '0;
        end else begin
            row            <= signed'(32'(v_cnt));
            column         <= signed'(32'(h_cnt));
            display_enable <= h_active && v_active;
            hsync          <= h_sync_on ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vsync          <= v_sync_on ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            line_start     <= at_line_start;
            frame_start    <= at_frame_start;
            vblank         <= ~v_active;
            // Counts in the same cycle frame_start rises, so the first
            // frame after reset reads 1.
            if (at_frame_start) begin
                frame_count <= frame_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_generator.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_generator
//
// Two instances share clock and reset: a reduced raster with active-high
// syncs (14 x 13 pixels, so whole frames are short) and the standard
// 640x480 raster with active-low syncs. A reference model derives the
// expected pixel from the number of clock edges since reset release using
// plain division / modulo; expected words go into queues on the rising
// edge and a monitor pops and compares them on the falling edge.
// ---------------------------------------------------------------------------
module tb_vga_timing_generator;

    // Reduced raster
    localparam int   SHV = 8,  SHF = 2, SHS = 3, SHB = 1;
    localparam int   SVV = 6,  SVF = 2, SVS = 2, SVB = 3;
    localparam logic SSA = 1'b1;
    // Standard raster
    localparam int   DHV = 640, DHF = 16, DHS = 96, DHB = 48;
    localparam int   DVV = 480, DVF = 10, DVS = 2,  DVB = 33;
    localparam logic DSA = 1'b0;

    typedef logic [101:0] vec_t;

    // ---------------- clock / reset ----------------
    logic vga_clock;
    logic reset;

    initial begin
        vga_clock = 1'b0;
        forever #5 vga_clock = ~vga_clock;
    end

    // ---------------- DUTs ----------------
    logic signed [31:0] s_row, s_column, d_row, d_column;
    logic s_de, s_hs, s_vs, s_ls, s_fs, s_vb;
    logic d_de, d_hs, d_vs, d_ls, d_fs, d_vb;
    logic [31:0] s_fc, d_fc;

    vga_timing_generator #(
        .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
        .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB),
        .SYNC_ACTIVE(SSA)
    ) dut_small (
        .vga_clock(vga_clock), .reset(reset),
        .row(s_row), .column(s_column), .display_enable(s_de),
        .hsync(s_hs), .vsync(s_vs), .line_start(s_ls),
        .frame_start(s_fs), .vblank(s_vb), .frame_count(s_fc)
    );

    vga_timing_generator #(
        .H_VISIBLE(DHV), .H_FRONT(DHF), .H_SYNC(DHS), .H_BACK(DHB),
        .V_VISIBLE(DVV), .V_FRONT(DVF), .V_SYNC(DVS), .V_BACK(DVB),
        .SYNC_ACTIVE(DSA)
    ) dut_std (
        .vga_clock(vga_clock), .reset(reset),
        .row(d_row), .column(d_column), .display_enable(d_de),
        .hsync(d_hs), .vsync(d_vs), .line_start(d_ls),
        .frame_start(d_fs), .vblank(d_vb), .frame_count(d_fc)
    );

    // ---------------- reference model ----------------
    function automatic vec_t pack(input logic [31:0] r, input logic [31:0] c,
                                  input logic de, input logic hs, input logic vs,
                                  input logic ls, input logic fs, input logic vb,
                                  input logic [31:0] fc);
        return {r, c, de, hs, vs, ls, fs, vb, fc};
    endfunction

    // Pixel shown after the (n+1)-th edge following reset release.
    function automatic vec_t model(input int n,
                                   input int hv, input int hf, input int hs, input int hb,
                                   input int vv, input int vf, input int vs, input int vb,
                                   input logic sa);
        int ht, vt, col, r, fc;
        logic hsv, vsv;
        ht  = hv + hf + hs + hb;
        vt  = vv + vf + vs + vb;
        col = n % ht;
        r   = (n / ht) % vt;
        fc  = n / (ht * vt) + 1;
        hsv = (col >= hv + hf && col < hv + hf + hs) ? sa : ~sa;
        vsv = (r >= vv + vf && r < vv + vf + vs) ? sa : ~sa;
        return pack(32'(r), 32'(col), (col < hv) && (r < vv), hsv, vsv,
                    col == 0, (col == 0) && (r == 0), r >= vv, 32'(fc));
    endfunction

    function automatic vec_t reset_vec(input logic sa);
        return pack(32'd0, 32'd0, 1'b0, ~sa, ~sa, 1'b0, 1'b0, 1'b0, 32'd0);
    endfunction

    // ---------------- scoreboard ----------------
    logic [101:0] exp_q_small[$];
    logic [101:0] exp_q_std[$];
    int checks = 0;
    int errors = 0;
    bit done   = 1'b0;

    task automatic check(input string name, input vec_t act, input vec_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got row=%0d col=%0d de/hs/vs/ls/fs/vb=%b fc=%0d expected row=%0d col=%0d de/hs/vs/ls/fs/vb=%b fc=%0d",
                     name, $time, act[101:70], act[69:38], act[37:32], act[31:0],
                     exp[101:70], exp[69:38], exp[37:32], exp[31:0]);
        end
    endtask

    // Expected-value producer: one entry per rising edge.
    initial begin
        int n;
        n = 0;
        forever begin
            @(posedge vga_clock);
            if (reset) begin
                exp_q_small.push_back(reset_vec(SSA));
                exp_q_std.push_back(reset_vec(DSA));
                n = 0;
            end else begin
                exp_q_small.push_back(model(n, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB, SSA));
                exp_q_std.push_back(model(n, DHV, DHF, DHS, DHB, DVV, DVF, DVS, DVB, DSA));
                n++;
            end
        end
    end

    // Monitor: outputs are sampled on the falling edge.
    initial begin
        forever begin
            @(negedge vga_clock);
            if (!done) begin
                if (exp_q_small.size() > 0) begin
                    check("small_pixel",
                          pack(s_row, s_column, s_de, s_hs, s_vs, s_ls, s_fs, s_vb, s_fc),
                          exp_q_small.pop_front());
                end
                if (exp_q_std.size() > 0) begin
                    check("std_pixel",
                          pack(d_row, d_column, d_de, d_hs, d_vs, d_ls, d_fs, d_vb, d_fc),
                          exp_q_std.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run_cycles(input int k);
        repeat (k) @(negedge vga_clock);
    endtask

    // Assert reset between edges and confirm the outputs drop without a
    // clock edge, then hold for a few cycles and release.
    task automatic apply_reset(input int hold);
        @(negedge vga_clock);
        #2 reset = 1'b1;
        #1;
        check("async_reset_small",
              pack(s_row, s_column, s_de, s_hs, s_vs, s_ls, s_fs, s_vb, s_fc), reset_vec(SSA));
        check("async_reset_std",
              pack(d_row, d_column, d_de, d_hs, d_vs, d_ls, d_fs, d_vb, d_fc), reset_vec(DSA));
        run_cycles(hold);
        #2 reset = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        run_cycles(3);
        #2 reset = 1'b0;

        // 1901 falling edges after release the standard raster is at
        // column 300 of its third line: reset it mid-line there.
        run_cycles(1900);
        apply_reset(2);

        for (int i = 0; i < 3; i++) begin
            run_cycles($urandom_range(300, 1500));
            apply_reset($urandom_range(1, 3));
        end

        // Long final run: many reduced frames, a few standard lines.
        run_cycles(2000);
        done = 1'b1;
        @(negedge vga_clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
